// File: rtl/sincos_pkg.sv
// Shared widths, quadrant encodings and the quarter-wave table generator
// for the sine/cosine lookup pipeline.
package sincos_pkg;

  localparam int ANGLE_W_DEF = 16;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 16;
  localparam int TAG_W_DEF   = 2;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  function automatic int FS(input int dataW);
    return (1 << (dataW - 1)) - 1;
  endfunction

  // Taylor series keeps table generation to plain real arithmetic at elaboration
  function automatic int rom_val(input int k, input int addrW, input int dataW);
    real x;
    real term;
    real sum;
    x    = 1.5707963267948966 * real'(k) / real'(1 << addrW);
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return $rtoi(real'(FS(dataW)) * sum + 0.5);
  endfunction

endpackage

// File: rtl/sincos_lut_pipe_if.sv
// Angle-in / sin-cos-out valid/ready bundle shared by the pipeline and its users.
interface sincos_lut_pipe_if
  import sincos_pkg::*;
#(
  parameter int ANGLE_W = ANGLE_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ANGLE_W-1:0]       angle;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] sin;
  logic signed [DATA_W-1:0] cos;
  logic [TAG_W-1:0]         out_tag;

  modport master (
    output in_valid, angle, in_tag, out_ready,
    input  in_ready, out_valid, sin, cos, out_tag
  );

  modport slave (
    input  in_valid, angle, in_tag, out_ready,
    output in_ready, out_valid, sin, cos, out_tag
  );
endinterface

// File: rtl/sincos_quarter_rom.sv
// Dual-read-port quarter-wave sine table, 2^ADDR_W+1 entries, registered
// outputs gated by a shared read enable.
module sincos_quarter_rom
  import sincos_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en_i,
  input  logic [ADDR_W:0]          addr_a_i,
  input  logic [ADDR_W:0]          addr_b_i,
  output logic signed [DATA_W-1:0] data_a_o,
  output logic signed [DATA_W-1:0] data_b_o
);
  localparam int DEPTH = (1 << ADDR_W) + 1;

  logic signed [DATA_W-1:0] romTable [DEPTH];
  logic signed [DATA_W-1:0] dataA_q;
  logic signed [DATA_W-1:0] dataB_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic signed [DATA_W-1:0] ENTRY = DATA_W'(rom_val(k, ADDR_W, DATA_W));
    assign romTable[k] = ENTRY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataA_q <= '0;
      dataB_q <= '0;
    end else if (rd_en_i) begin
      dataA_q <= romTable[addr_a_i];
      dataB_q <= romTable[addr_b_i];
    end
  end

  assign data_a_o = dataA_q;
  assign data_b_o = dataB_q;
endmodule

// File: rtl/sincos_lut_pipe.sv
// Three-stage sin/cos generator: quadrant fold, quarter-wave ROM read, sign
// correction, with a single global stall driven by the output handshake.
module sincos_lut_pipe
  import sincos_pkg::*;
#(
  parameter int ANGLE_W = ANGLE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  sincos_lut_pipe_if.slave bus
);
  localparam logic [ADDR_W:0] QUARTER = {1'b1, {ADDR_W{1'b0}}};

  logic                     advance;
  logic                     unusedAngleBits;
  quadrant_e                quad_d;
  logic [ADDR_W:0]          idxExt;
  logic [ADDR_W:0]          sinAddr_d;
  logic [ADDR_W:0]          cosAddr_d;

  logic                     s1Valid_q;
  logic [ADDR_W:0]          s1SinAddr_q;
  logic [ADDR_W:0]          s1CosAddr_q;
  quadrant_e                s1Quad_q;
  logic [TAG_W-1:0]         s1Tag_q;

  logic                     s2Valid_q;
  quadrant_e                s2Quad_q;
  logic [TAG_W-1:0]         s2Tag_q;
  logic signed [DATA_W-1:0] romSin;
  logic signed [DATA_W-1:0] romCos;

  logic                     outValid_q;
  logic signed [DATA_W-1:0] sin_q;
  logic signed [DATA_W-1:0] cos_q;
  logic [TAG_W-1:0]         outTag_q;
  logic signed [DATA_W-1:0] sinOut_d;
  logic signed [DATA_W-1:0] cosOut_d;

  assign advance         = ~outValid_q | bus.out_ready;
  assign unusedAngleBits = ^bus.angle;

  // Odd quadrants mirror the index so one quarter-wave serves the whole circle
  always_comb begin
    quad_d    = quadrant_e'(bus.angle[ANGLE_W-1 -: 2]);
    idxExt    = {1'b0, bus.angle[ANGLE_W-3 -: ADDR_W]};
    sinAddr_d = idxExt;
    cosAddr_d = QUARTER - idxExt;
    if (quad_d == Q1 || quad_d == Q3) begin
      sinAddr_d = QUARTER - idxExt;
      cosAddr_d = idxExt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q   <= 1'b0;
      s1SinAddr_q <= '0;
      s1CosAddr_q <= '0;
      s1Quad_q    <= Q0;
      s1Tag_q     <= '0;
      s2Valid_q   <= 1'b0;
      s2Quad_q    <= Q0;
      s2Tag_q     <= '0;
    end else if (advance) begin
      s1Valid_q   <= bus.in_valid;
      s1SinAddr_q <= sinAddr_d;
      s1CosAddr_q <= cosAddr_d;
      s1Quad_q    <= quad_d;
      s1Tag_q     <= bus.in_tag;
      s2Valid_q   <= s1Valid_q;
      s2Quad_q    <= s1Quad_q;
      s2Tag_q     <= s1Tag_q;
    end
  end

  sincos_quarter_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en_i  (advance),
    .addr_a_i (s1SinAddr_q),
    .addr_b_i (s1CosAddr_q),
    .data_a_o (romSin),
    .data_b_o (romCos)
  );

  // Table values never exceed FS, so negation cannot overflow
  always_comb begin
    sinOut_d = romSin;
    cosOut_d = romCos;
    if (s2Quad_q == Q2 || s2Quad_q == Q3) sinOut_d = -romSin;
    if (s2Quad_q == Q1 || s2Quad_q == Q2) cosOut_d = -romCos;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      sin_q      <= '0;
      cos_q      <= '0;
      outTag_q   <= '0;
    end else if (advance) begin
      outValid_q <= s2Valid_q;
      sin_q      <= sinOut_d;
      cos_q      <= cosOut_d;
      outTag_q   <= s2Tag_q;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = outValid_q;
  assign bus.sin       = sin_q;
  assign bus.cos       = cos_q;
  assign bus.out_tag   = outTag_q;
endmodule

// File: tb/tb_sincos_lut_pipe.sv
// Scoreboard bench for sincos_lut_pipe: expected results are queued on accept
// and compared as each output is taken.
module tb_sincos_lut_pipe;
  localparam int ANGLE_W = 16;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TAG_W   = 2;
  localparam real PI     = 3.14159265358979323846;

  typedef struct {
    int tagV;
    int sinV;
    int cosV;
    int tol;
    int acceptCycle;
    bit chkLat;
  } expItem_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sincos_lut_pipe_if #(.ANGLE_W(ANGLE_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  sincos_lut_pipe #(
    .ANGLE_W (ANGLE_W),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  expItem_t sbQueue[$];
  expItem_t pendingItem;
  expItem_t popItem;
  int checkCount = 0;
  int errorCount = 0;
  int cycleCount = 0;
  int outCount   = 0;
  int outMark;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Every comparison in the bench funnels through here
  task automatic checkOutput(input string tag, input int observed, input int expected,
                             input int tol = 0);
    int diff;
    checkCount++;
    diff = observed - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d",
               tag, observed, expected, tol, cycleCount);
    end
  endtask

  function automatic int refVal(input int a, input bit isCos);
    real ph;
    real v;
    int  at;
    at = a & 32'h0000FFC0;
    ph = 2.0 * PI * real'(at) / 65536.0;
    v  = 32767.0 * (isCos ? $cos(ph) : $sin(ph));
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Handshakes are evaluated half a cycle before the edge that completes them
  always @(negedge clk) begin
    if (!rst_n) begin
      sbQueue.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("spurious out_valid", int'(bus.out_valid), 0);
        end else begin
          popItem = sbQueue.pop_front();
          outCount++;
          checkOutput("sin", int'(bus.sin), popItem.sinV, popItem.tol);
          checkOutput("cos", int'(bus.cos), popItem.cosV, popItem.tol);
          checkOutput("out_tag", int'(bus.out_tag), popItem.tagV);
          if (popItem.chkLat)
            checkOutput("latency", cycleCount - popItem.acceptCycle, 3);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        pendingItem.acceptCycle = cycleCount;
        sbQueue.push_back(pendingItem);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] ang, input int tagV, input int sinV,
                               input int cosV, input int tol, input bit chkLat);
    bit acc;
    int waitCycles;
    pendingItem.tagV   = tagV;
    pendingItem.sinV   = sinV;
    pendingItem.cosV   = cosV;
    pendingItem.tol    = tol;
    pendingItem.chkLat = chkLat;
    bus.angle    = ang;
    bus.in_tag   = TAG_W'(tagV);
    bus.in_valid = 1'b1;
    waitCycles   = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waitCycles++;
    end while (!acc && waitCycles < 100);
    if (!acc) checkOutput("accept timeout", int'(acc), 1);
  endtask

  task automatic applyRef(input int a, input int tagV, input bit chkLat);
    applyStimulus(16'(a), tagV, refVal(a, 1'b0), refVal(a, 1'b1), 1, chkLat);
  endtask

  task automatic waitDrain();
    int n;
    bus.in_valid = 1'b0;
    n = 0;
    while ((sbQueue.size() != 0 || bus.out_valid) && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain queue size", sbQueue.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b1;
    bus.angle     = 16'h4000;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    pendingItem   = '{default: 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", int'(bus.out_valid), 0);
    checkOutput("reset sin", int'(bus.sin), 0);
    checkOutput("reset cos", int'(bus.cos), 0);
    checkOutput("reset out_tag", int'(bus.out_tag), 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("in_ready after reset", int'(bus.in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle out_valid", int'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;

    $display("[TB] cardinal points");
    applyStimulus(16'h0000, 0, 0, 32767, 0, 1'b1);
    applyStimulus(16'h4000, 1, 32767, 0, 0, 1'b1);
    applyStimulus(16'h8000, 2, 0, -32767, 0, 1'b1);
    applyStimulus(16'hC000, 3, -32767, 0, 0, 1'b1);
    applyStimulus(16'h2000, 1, 23170, 23170, 0, 1'b1);
    applyStimulus(16'hA000, 2, -23170, -23170, 0, 1'b1);
    applyStimulus(16'h203F, 3, 23170, 23170, 0, 1'b1);
    waitDrain();

    $display("[TB] backpressure");
    @(posedge clk);
    #1;
    outMark = outCount;
    applyRef(16'h1234, 1, 1'b0);
    applyRef(16'h5678, 2, 1'b0);
    applyRef(16'h9ABC, 3, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stall in_ready", int'(bus.in_ready), 0);
      checkOutput("stall out_valid", int'(bus.out_valid), 1);
      checkOutput("stall sin", int'(bus.sin), sbQueue[0].sinV, 1);
      checkOutput("stall cos", int'(bus.cos), sbQueue[0].cosV, 1);
      checkOutput("stall out_tag", int'(bus.out_tag), sbQueue[0].tagV);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    waitDrain();
    checkOutput("backpressure outputs", outCount - outMark, 3);

    $display("[TB] reset mid-stream");
    @(posedge clk);
    #1;
    applyRef(16'h0F00, 0, 1'b0);
    applyRef(16'h3F00, 1, 1'b0);
    applyRef(16'h7F00, 2, 1'b0);
    bus.in_valid = 1'b0;
    checkOutput("pre-reset out_valid", int'(bus.out_valid), 1);
    #1 rst_n = 1'b0;
    #1 checkOutput("async reset out_valid", int'(bus.out_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    outMark = outCount;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("flushed out_valid", int'(bus.out_valid), 0);
    end
    checkOutput("flushed outputs", outCount - outMark, 0);

    $display("[TB] full sweep");
    @(posedge clk);
    #1;
    outMark = outCount;
    for (int a = 0; a < 65536; a++) applyRef(a, a % 4, 1'b1);
    waitDrain();
    checkOutput("sweep outputs", outCount - outMark, 65536);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/sincos_lut_pipe.md
# sincos_lut_pipe

Parametrised, pipelined sine/cosine generator for the FOC datapath. It replaces the fixed-width angle-to-sin/cos lookup. Each angle word is folded onto a single quarter-wave ROM, looked up, and sign-corrected, producing sin and cos per accepted sample at one sample per clock. Every stage runs on the system clock; there is no internal clock divider. A valid/ready handshake and a channel tag let several motor axes share one instance ahead of the Park/inverse-Park blocks.

## Interface
- ANGLE_W, 16: angle input width; full circle = 2^ANGLE_W; must be ≥ ADDR_W+2
- ADDR_W, 8: quarter-wave index width; ROM holds 2^ADDR_W+1 entries
- DATA_W, 16: signed output width, Q1.(DATA_W-1); full scale FS = 2^(DATA_W-1)-1
- TAG_W, 2: width of channel tag carried alongside each sample
- clk  in  1  system clock, all logic single-clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  angle/tag presented
- in_ready  out  1  block accepts on in_valid & in_ready
- angle  in  ANGLE_W  unsigned angle, 0 = 0°, 2^(ANGLE_W-2) = 90°
- in_tag  in  TAG_W  channel id
- out_valid  out  1  sin/cos/out_tag valid
- out_ready  in  1  downstream accepts on out_valid & out_ready
- sin  out  DATA_W  signed sine
- cos  out  DATA_W  signed cosine
- out_tag  out  TAG_W  tag of the sample on sin/cos

## Operation
- Quadrant q = angle[ANGLE_W-1:ANGLE_W-2]. Index i = angle[ANGLE_W-3 -: ADDR_W]. The remaining low bits are truncated, with no rounding.
- Fold, with N = 2^ADDR_W:
  - sin_addr = q[0] ? N-i : i
  - cos_addr = q[0] ? i : N-i
  - Both addresses are ADDR_W+1 bits wide.
- ROM[k] = round(FS·sin(π/2·k/N)) for k = 0..N. ROM[0] = 0 and ROM[N] = FS exactly.
- Sign rules:
  - sin is negated when q[1]=1.
  - cos is negated when q[1]^q[0]=1.
  - Negation is two's complement of a value ≤ FS, so it cannot overflow; −0 yields 0.
- Pipeline stages:
  - S1 registers the fold addresses, q and tag.
  - S2 does the synchronous dual-port ROM read.
  - S3 applies the sign and drives the output registers.
- Each stage has a valid bit that travels with its data.
- Global stall: advance = ~out_valid | out_ready. While advance is 0, every stage register, including the ROM output enable, holds its value.
- in_ready = advance. It is combinational from out_ready and out_valid only.

## Timing
- Latency is 3 clocks from the accepting edge to the edge where out_valid rises, assuming no stall.
- Throughput is 1 sample/clk with out_ready held high.
- While out_valid=1 and out_ready=0, sin, cos and out_tag are stable.
- Reset state, applied asynchronously:
  - all stage valid bits are 0, so out_valid=0
  - sin=0, cos=0, out_tag=0
  - ROM output registers are 0
- in_ready is 1 immediately after reset.
- Reset mid-operation flushes all in-flight samples; none appear after release.
- Simultaneous accept at the input and drain at the output in the same cycle is legal; no bubble is inserted.
- Samples leave in acceptance order; tags are never reordered.

## Structure
- Package sincos_pkg holds:
  - default ANGLE_W/ADDR_W/DATA_W/TAG_W
  - function FS(DATA_W)
  - the quadrant encodings Q0..Q3
  - ROM init function rom_val(k, ADDR_W, DATA_W)
- Sub-module sincos_quarter_rom:
  - parameters ADDR_W, DATA_W
  - two read ports, synchronous read with read enable
  - contents built at elaboration from rom_val
- Top level contains the fold, the valid/stall control and the sign stage.

## Test plan
All scenarios use defaults 16/8/16/2.
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0, sin=cos=0, no output for 5 clocks after release without new input.
- Cardinal points, each accepted on a separate cycle with out_ready=1:
  - 0x0000 → sin 0, cos 32767
  - 0x4000 → 32767, 0
  - 0x8000 → 0, −32767 (0x8001)
  - 0xC000 → −32767, 0
  - every output appears exactly 3 clocks after acceptance.
- 45°/225°: 0x2000 → sin=cos=23170; 0xA000 → sin=cos=−23170. Truncation check: 0x203F gives the same result as 0x2000.
- Back-to-back sweep: all 65536 angles with tags cycling 0..3 and out_ready=1 → one output per clock after the 3-clock fill, in order, tags matched. Each result is within 1 LSB of a reference model of the truncated angle.
- Backpressure: 3 samples in flight, then out_ready=0 for 4 clocks → in_ready=0, outputs frozen. After out_ready returns to 1, all samples drain in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 while 3 samples are in flight → out_valid drops asynchronously, and those samples never emerge after release.
